// File: rtl/reg_file_writer.sv
// Write side of the register file: valid/ready write queue draining into the array, plus a registered read port.
// Optional macro REGFILE_WR_FWD_EN enables read forwarding from the incoming write and the queued writes.
module reg_file_writer #(
    parameter int NREGS = 10,
    parameter int DW    = 32,
    parameter int AW    = 4,
    parameter int DEPTH = 4      // power of two, >= 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [AW-1:0]            wr_addr,
    input  logic [DW-1:0]            wr_data,
    input  logic                     hold,
    input  logic [AW-1:0]            rd_addr,
    output logic [DW-1:0]            rd_data,
    output logic                     stall,
    output logic [$clog2(DEPTH):0]   pending,
    output logic                     err
);
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    entry_t        q [DEPTH];
    logic [PW-1:0] head, tail;
    logic [DW-1:0] regs [NREGS];
    logic [DW-1:0] rd_val;
    logic          full, accept, drain;

    // Full blocks accepts even when a drain happens the same cycle.
    assign full     = (pending == (PW+1)'(DEPTH));
    assign wr_ready = !full;
    assign stall    = full;
    assign accept   = wr_valid && wr_ready;
    assign drain    = (pending != '0) && !hold;

    always_comb begin
        rd_val = '0;
        if (rd_addr < AW'(NREGS)) begin
            rd_val = regs[rd_addr];
`ifdef REGFILE_WR_FWD_EN
            // Walk oldest to youngest so the youngest match wins.
            for (int i = 0; i < DEPTH; i++) begin
                logic [PW-1:0] idx;
                idx = head + PW'(i);
                if (((PW+1)'(i) < pending) && (q[idx].addr == rd_addr))
                    rd_val = q[idx].data;
            end
            if (accept && (wr_addr == rd_addr))
                rd_val = wr_data;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (accept && !rst)
            q[tail] <= '{addr: wr_addr, data: wr_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            pending <= '0;
            err     <= 1'b0;
            rd_data <= '0;
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else begin
            if (accept) begin
                tail <= tail + 1'b1;
                if (wr_addr >= AW'(NREGS))
                    err <= 1'b1;
            end
            if (drain) begin
                head <= head + 1'b1;
                if (q[head].addr < AW'(NREGS))
                    regs[q[head].addr] <= q[head].data;
            end
            case ({accept, drain})
                2'b10:   pending <= pending + 1'b1;
                2'b01:   pending <= pending - 1'b1;
                default: ;
            endcase
            rd_data <= rd_val;
        end
    end
endmodule

// File: tb/tb_reg_file_writer.sv
// Scoreboard bench for reg_file_writer: expected read values are queued when a read is driven and popped after the edge.
module tb_reg_file_writer;
    logic        clk = 1'b0;
    logic        rst, wr_valid, hold;
    logic        wr_ready, stall, err;
    logic [3:0]  wr_addr, rd_addr;
    logic [31:0] wr_data, rd_data;
    logic [2:0]  pending;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] sb [$];
    logic [31:0] model [10];
    logic [31:0] exp_v;

    reg_file_writer dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .hold(hold), .rd_addr(rd_addr),
        .rd_data(rd_data), .stall(stall), .pending(pending), .err(err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one read, queue its expectation, then compare after the edge.
    task automatic read_chk(input logic [3:0] a, input logic [31:0] e, input string nm);
        rd_addr = a;
        sb.push_back(e);
        step();
        exp_v = sb.pop_front();
        n_tests++;
        if (rd_data !== exp_v) begin
            n_fail++;
            $display("FAIL %s addr=%0d got=%h exp=%h", nm, a, rd_data, exp_v);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_valid = 1'b0; hold = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        step(); step();
        rst = 1'b0;
        step();
        n_tests++;
        if (pending !== 3'd0 || wr_ready !== 1'b1 || stall !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state pending=%0d ready=%b stall=%b err=%b exp 0/1/0/0",
                     pending, wr_ready, stall, err);
        end
        for (int i = 0; i < 10; i++) model[i] = '0;
        for (int i = 0; i < 10; i++) read_chk(4'(i), 32'h0, "reset_read");
    endtask

    task automatic test_write();
        wr_valid = 1'b1; wr_addr = 4'd3; wr_data = 32'hDEADBEEF;
        step();
        wr_valid = 1'b0;
        n_tests++;
        if (pending !== 3'd1) begin
            n_fail++; $display("FAIL write_accept pending=%0d exp=1", pending);
        end
        step();
        n_tests++;
        if (pending !== 3'd0) begin
            n_fail++; $display("FAIL write_drain pending=%0d exp=0", pending);
        end
        model[3] = 32'hDEADBEEF;
        read_chk(4'd3, 32'hDEADBEEF, "write_read");
    endtask

    task automatic test_hold_full();
        logic [2:0] exp_p [5] = '{3'd3, 3'd3, 3'd2, 3'd1, 3'd0};
        hold = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            wr_valid = 1'b1; wr_addr = 4'(k); wr_data = 32'(k);
            step();
        end
        wr_addr = 4'd5; wr_data = 32'd5;
        step(); step();
        n_tests++;
        if (pending !== 3'd4 || stall !== 1'b1 || wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_state pending=%0d stall=%b ready=%b exp 4/1/0", pending, stall, wr_ready);
        end
        hold = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (c == 1) wr_valid = 1'b0;
            n_tests++;
            if (pending !== exp_p[c]) begin
                n_fail++; $display("FAIL drain_seq cycle=%0d pending=%0d exp=%0d", c, pending, exp_p[c]);
            end
            if (c == 0) begin
                n_tests++;
                if (wr_ready !== 1'b1 || stall !== 1'b0) begin
                    n_fail++; $display("FAIL ready_after_drain ready=%b stall=%b exp 1/0", wr_ready, stall);
                end
            end
        end
        for (int k = 1; k <= 5; k++) model[k] = 32'(k);
        for (int k = 1; k <= 5; k++) read_chk(4'(k), model[k], "hold_read");
    endtask

    task automatic test_same_addr();
        hold = 1'b1;
        wr_valid = 1'b1; wr_addr = 4'd7; wr_data = 32'h11;
        step();
        wr_data = 32'h22;
        step();
        wr_valid = 1'b0;
`ifdef REGFILE_WR_FWD_EN
        read_chk(4'd7, 32'h22, "same_addr_fwd");
`else
        read_chk(4'd7, 32'h0, "same_addr_stale");
`endif
        hold = 1'b0;
        step(); step();
        n_tests++;
        if (pending !== 3'd0) begin
            n_fail++; $display("FAIL same_addr_drain pending=%0d exp=0", pending);
        end
        model[7] = 32'h22;
        read_chk(4'd7, 32'h22, "same_addr_final");
    endtask

    task automatic test_out_of_range();
        n_tests++;
        if (err !== 1'b0) begin
            n_fail++; $display("FAIL oor_pre err=%b exp=0", err);
        end
        wr_valid = 1'b1; wr_addr = 4'd12; wr_data = 32'hFF;
        read_chk(4'd12, 32'h0, "oor_read_accept");
        wr_valid = 1'b0;
        n_tests++;
        if (err !== 1'b1) begin
            n_fail++; $display("FAIL oor_err_set err=%b exp=1", err);
        end
        step(); step();
        n_tests++;
        if (err !== 1'b1 || pending !== 3'd0) begin
            n_fail++; $display("FAIL oor_sticky err=%b pending=%0d exp 1/0", err, pending);
        end
        read_chk(4'd12, 32'h0, "oor_read");
        read_chk(4'd15, 32'h0, "oor_read_15");
        for (int i = 0; i < 10; i++) read_chk(4'(i), model[i], "oor_array");
    endtask

    task automatic test_reset_mid();
        hold = 1'b1;
        wr_valid = 1'b1; wr_addr = 4'd0; wr_data = 32'hA; step();
        wr_addr = 4'd8; wr_data = 32'hB; step();
        wr_addr = 4'd9; wr_data = 32'hC; step();
        n_tests++;
        if (pending !== 3'd3) begin
            n_fail++; $display("FAIL mid_queue pending=%0d exp=3", pending);
        end
        // Reset also overrides an accept presented in the same cycle.
        wr_addr = 4'd1; wr_data = 32'h99;
        rst = 1'b1;
        step();
        rst = 1'b0; wr_valid = 1'b0;
        n_tests++;
        if (pending !== 3'd0 || err !== 1'b0 || wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset pending=%0d err=%b ready=%b exp 0/0/1", pending, err, wr_ready);
        end
        hold = 1'b0;
        step(); step(); step();
        n_tests++;
        if (pending !== 3'd0) begin
            n_fail++; $display("FAIL mid_release pending=%0d exp=0", pending);
        end
        for (int i = 0; i < 10; i++) read_chk(4'(i), 32'h0, "mid_reset_read");
    endtask

    initial begin
        test_reset();
        test_write();
        test_hold_full();
        test_same_addr();
        test_out_of_range();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout tests_run=%0d", n_tests);
        $fatal(1, "timeout");
    end
endmodule
